srfifo_gen: RTL and testbench
=============================

# srfifo_gen

Parametrised shift-register FIFO, the next-generation replacement for the fixed 4-bit × 16 shift-register FIFO used in the FIFO verification testcases. Entries shift in at slot 0 and are read from the slot addressed by the occupancy count. It generalises width, depth and flag thresholds, and accepts simultaneous push and pop, including push while full. It exposes occupancy, almost-full/almost-empty flags and optional sticky error flags, and serves as a datapath buffer and as a GSTE assertion-graph target.

## Interface
- WIDTH, 4: data width in bits, ≥1.
- DEPTH, 16: number of entries, ≥2.
- AF_LEVEL, DEPTH-2: almostFull asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2: almostEmpty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.
- clock  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- dataIn  in  WIDTH  write data.
- push  in  1  write request.
- pop  in  1  read request.
- dataOut  out  WIDTH  head (oldest) entry; all zeros when empty.
- count  out  CW  occupancy 0..DEPTH, where CW = clog2(DEPTH+1).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almostFull  out  1  count ≥ AF_LEVEL.
- almostEmpty  out  1  count ≤ AE_LEVEL.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

## Operation
- Storage: mem[0..DEPTH-1]. mem[0] holds the newest entry; the head is mem[count-1].
- Accept rules:
  - popAcc = pop & ~empty.
  - pushAcc = push & (~full | popAcc).
- Accepted push: mem[i] ← mem[i-1] for i = DEPTH-1..1, then mem[0] ← dataIn.
- count update:
  - count + 1 on pushAcc & ~popAcc.
  - count − 1 on popAcc & ~pushAcc.
  - Unchanged on both or neither.
- Push and pop together, not empty: shift and count unchanged. The old head falls out of the addressed window, so the new head is the next-oldest entry.
- Push and pop together while full: both are accepted. Count stays at DEPTH and no overflow is flagged.
- Push and pop together while empty: the push is accepted and the pop is rejected (underflow). count becomes 1.
- Push while full without pop: rejected. Memory and count are unchanged and overflow is set.
- Pop while empty: rejected and underflow is set.
- All flags are pure combinational decodes of count. count never exceeds DEPTH and never wraps below 0.
- Reset:
  - count = 0, which gives empty=1, full=0, almostEmpty=1 and almostFull=0 (AF_LEVEL ≥ 1).
  - dataOut = 0.
  - overflow = 0, underflow = 0.
  - mem is not cleared. Stale contents are never visible because dataOut is masked when empty.
- Reset has priority over push and pop in the same cycle. A reset mid-stream discards all entries.

## Timing
- Write-to-read latency is 1 cycle. Data pushed at edge N appears on dataOut after edge N when the FIFO was empty.
- dataOut, flags and count are combinational from registered state only, with no input-to-output combinational path.
- A pop takes effect at the edge. dataOut shows the next entry in the same cycle the new count is visible.
- overflow and underflow set at the edge following the offending request and clear only on rst.

## Configuration
- SRFIFO_ERR_EN defined: overflow and underflow are sticky registers as described.
- SRFIFO_ERR_EN undefined: overflow and underflow are tied to 0 and no error registers exist. Accept rules are identical in both cases.

## Structure
- Package srfifo_pkg holds:
  - the function computing CW from DEPTH;
  - the localparam defaults;
  - the parameter-legality check (elaboration error if DEPTH < 2 or a level is out of range).
- Sub-module srfifo_occ holds the occupancy counter, the accept logic, flag decode and error registers. The top level holds the shift array and the head mux.

## Test plan
- Reset then idle: count=0, empty=1, almostEmpty=1, dataOut=0; overflow and underflow are 0.
- Push 0x1,0x2,0x3 then pop ×3: dataOut reads 0x1,0x2,0x3 in order, then empty=1 and dataOut=0.
- Push 16 entries with DEPTH=16: full=1 and almostFull asserted at count=14. A 17th push is rejected, count stays 16 and overflow=1 (SRFIFO_ERR_EN).
- While full, push 0xA with pop in the same cycle: count stays 16, the old head leaves, and 0xA is at mem[0]. Drain 16 pops; 0xA is last out.
- While empty, push 0x5 with pop in the same cycle: count=1, dataOut=0x5, underflow=1. Without SRFIFO_ERR_EN, underflow stays 0.
- With count=7, assert rst together with push: count=0 next cycle, the push is dropped, and flags return to reset values.

Source files
------------

// File: rtl/srfifo_pkg.sv
// srfifo_pkg: shared defaults, counter-width helper and parameter legality
// check for the parametrised shift-register FIFO (srfifo_gen).
package srfifo_pkg;

    localparam int unsigned DEF_WIDTH    = 4;
    localparam int unsigned DEF_DEPTH    = 16;
    localparam int unsigned DEF_AE_LEVEL = 2;

    // Occupancy counter width: must hold 0..depth inclusive.
    function automatic int unsigned cw_of(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // True when the configuration is buildable.
    function automatic bit params_legal(input int unsigned width,
                                        input int unsigned depth,
                                        input int unsigned af_level,
                                        input int unsigned ae_level);
        return (width >= 1) && (depth >= 2) &&
               (af_level >= 1) && (af_level <= depth) &&
               (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/srfifo_gen_if.sv
// srfifo_gen_if: FIFO data/handshake/status bundle.
//   master: drives dataIn, push, pop; observes data and status.
//   slave : the FIFO side.
interface srfifo_gen_if
    import srfifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
);
    localparam int unsigned CW = cw_of(DEPTH);

    logic [WIDTH-1:0] dataIn;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] dataOut;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             almostFull;
    logic             almostEmpty;
    logic             overflow;
    logic             underflow;

    modport master (
        output dataIn, push, pop,
        input  dataOut, count, full, empty, almostFull, almostEmpty,
               overflow, underflow
    );

    modport slave (
        input  dataIn, push, pop,
        output dataOut, count, full, empty, almostFull, almostEmpty,
               overflow, underflow
    );

endinterface

// File: rtl/srfifo_occ.sv
// srfifo_occ: occupancy counter, accept logic, flag decode and the optional
// sticky error registers (present only when SRFIFO_ERR_EN is defined).
// Ports:
//   clock, rst      : clock, synchronous active-high reset
//   push_i, pop_i   : raw requests
//   push_acc_o      : push accepted this cycle (drives the shift array)
//   count_o         : occupancy 0..DEPTH
//   full_o, empty_o, almost_full_o, almost_empty_o : decodes of count
//   overflow_o, underflow_o : sticky rejected-push / rejected-pop flags
module srfifo_occ
    import srfifo_pkg::*;
#(
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = DEF_AE_LEVEL,
    localparam int unsigned CW      = cw_of(DEPTH)
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    output logic          push_acc_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          almost_full_o,
    output logic          almost_empty_o,
    output logic          overflow_o,
    output logic          underflow_o
);

    logic [CW-1:0] count_q, count_d;
    logic          pop_acc;
    logic          push_acc;

    // Flags decode registered count only.
    assign full_o         = (count_q == CW'(DEPTH));
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty_o = (count_q <= CW'(AE_LEVEL));
    assign count_o        = count_q;

    // A pop frees a slot, so push while full is accepted if the pop is.
    assign pop_acc    = pop_i & ~empty_o;
    assign push_acc   = push_i & (~full_o | pop_acc);
    assign push_acc_o = push_acc;

    // Next occupancy.
    always_comb begin
        count_d = count_q;
        if (push_acc && !pop_acc) begin
            count_d = count_q + CW'(1);
        end else if (pop_acc && !push_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

`ifdef SRFIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky until reset.
    always_comb begin
        overflow_d  = overflow_q | (push_i & ~push_acc);
        underflow_d = underflow_q | (pop_i & ~pop_acc);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

endmodule

// File: rtl/srfifo_gen.sv
// srfifo_gen: parametrised shift-register FIFO. New entries enter at mem[0];
// the head (oldest) is mem[count-1]. dataOut is forced to zero when empty so
// stale storage (never cleared by reset) is never visible.
// Ports:
//   clock : clock, rising edge
//   rst   : synchronous active-high reset (clears occupancy and error flags)
//   bus   : srfifo_gen_if slave (dataIn/push/pop in; dataOut/count/flags out)
// Optional feature: define SRFIFO_ERR_EN to build the sticky overflow and
// underflow registers; otherwise those outputs are tied to 0.
module srfifo_gen
    import srfifo_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic        clock,
    input  logic        rst,
    srfifo_gen_if.slave bus
);

    localparam int unsigned CW = cw_of(DEPTH);
    localparam int unsigned IW = $clog2(DEPTH);

    if (!params_legal(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("srfifo_gen: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_acc;
    logic [CW-1:0]    count;
    logic             empty;
    logic [IW-1:0]    head_idx;

    srfifo_occ #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) u_occ (
        .clock          (clock),
        .rst            (rst),
        .push_i         (bus.push),
        .pop_i          (bus.pop),
        .push_acc_o     (push_acc),
        .count_o        (count),
        .full_o         (bus.full),
        .empty_o        (empty),
        .almost_full_o  (bus.almostFull),
        .almost_empty_o (bus.almostEmpty),
        .overflow_o     (bus.overflow),
        .underflow_o    (bus.underflow)
    );

    // Shift array; no reset since occupancy alone defines valid contents.
    always_ff @(posedge clock) begin
        if (push_acc) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
            mem_q[0] <= bus.dataIn;
        end
    end

    // Head mux; index is meaningless when empty, hence the mask.
    assign head_idx    = IW'(count - CW'(1));
    assign bus.dataOut = empty ? '0 : mem_q[head_idx];
    assign bus.count   = count;
    assign bus.empty   = empty;

endmodule

// File: tb/tb_srfifo_gen.sv
// tb_srfifo_gen: directed scoreboard bench for srfifo_gen (WIDTH=4, DEPTH=16,
// AF_LEVEL=14, AE_LEVEL=2). Each vector queues the hand-computed state the
// FIFO must show after the next edge; a monitor pops and compares.
module tb_srfifo_gen;

    localparam int unsigned W  = 4;
    localparam int unsigned D  = 16;
    localparam int unsigned CW = 5;
`ifdef SRFIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic [W-1:0]  dout;
        logic          full;
        logic          empty;
        logic          af;
        logic          ae;
        logic          ovf;
        logic          unf;
    } exp_t;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    exp_t  exp_q  [$];
    string name_q [$];
    int    n_vec  = 0;
    int    n_bad  = 0;

    srfifo_gen_if #(.WIDTH(W), .DEPTH(D)) bus ();

    srfifo_gen #(
        .WIDTH    (W),
        .DEPTH    (D),
        .AF_LEVEL (14),
        .AE_LEVEL (2)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Apply one vector and queue the state expected after the next edge.
    task automatic vec(input logic r, input logic pu, input logic po,
                       input logic [W-1:0] din, input int cnt,
                       input logic [W-1:0] dout, input logic ovf,
                       input logic unf, input string nm);
        exp_t e;
        @(negedge clock);
        rst        = r;
        bus.push   = pu;
        bus.pop    = po;
        bus.dataIn = din;
        e.cnt   = CW'(cnt);
        e.dout  = dout;
        e.full  = (cnt == 16);
        e.empty = (cnt == 0);
        e.af    = (cnt >= 14);
        e.ae    = (cnt <= 2);
        e.ovf   = ovf & ERR_EN;
        e.unf   = unf & ERR_EN;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare the DUT state just after each edge with the queue head.
    initial begin
        exp_t  e;
        exp_t  a;
        string nm;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a.cnt   = bus.count;
                a.dout  = bus.dataOut;
                a.full  = bus.full;
                a.empty = bus.empty;
                a.af    = bus.almostFull;
                a.ae    = bus.almostEmpty;
                a.ovf   = bus.overflow;
                a.unf   = bus.underflow;
                n_vec++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL %s: got cnt=%0d dout=%h full=%b empty=%b af=%b ae=%b ovf=%b unf=%b, want cnt=%0d dout=%h full=%b empty=%b af=%b ae=%b ovf=%b unf=%b",
                             nm, a.cnt, a.dout, a.full, a.empty, a.af, a.ae, a.ovf, a.unf,
                             e.cnt, e.dout, e.full, e.empty, e.af, e.ae, e.ovf, e.unf);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] drain_exp [16];
        int           waited;
        drain_exp = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA,
                      4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'hA, 4'h0};
        bus.push   = 1'b0;
        bus.pop    = 1'b0;
        bus.dataIn = '0;

        // Reset and idle.
        vec(1, 0, 0, 4'h0, 0, 4'h0, 0, 0, "reset");
        vec(0, 0, 0, 4'h0, 0, 4'h0, 0, 0, "idle");

        // FIFO ordering.
        vec(0, 1, 0, 4'h1, 1, 4'h1, 0, 0, "push1");
        vec(0, 1, 0, 4'h2, 2, 4'h1, 0, 0, "push2");
        vec(0, 1, 0, 4'h3, 3, 4'h1, 0, 0, "push3");
        vec(0, 0, 1, 4'h0, 2, 4'h2, 0, 0, "pop1");
        vec(0, 0, 1, 4'h0, 1, 4'h3, 0, 0, "pop2");
        vec(0, 0, 1, 4'h0, 0, 4'h0, 0, 0, "pop3_empty");

        // Fill to DEPTH with 1..15,0; head stays 1.
        for (int i = 0; i < 16; i++) begin
            vec(0, 1, 0, W'(i + 1), i + 1, 4'h1, 0, 0, $sformatf("fill%0d", i + 1));
        end

        // Rejected push while full.
        vec(0, 1, 0, 4'h7, 16, 4'h1, 1, 0, "push_full_reject");

        // Push+pop while full: head 1 leaves, 0xA enters.
        vec(0, 1, 1, 4'hA, 16, 4'h2, 1, 0, "pushpop_full");

        // Drain: 2 already at head, then 3..F, 0, A last.
        for (int k = 0; k < 16; k++) begin
            vec(0, 0, 1, 4'h0, 15 - k, drain_exp[k], 1, 0, $sformatf("drain%0d", k + 1));
        end

        // Push+pop while empty: push taken, pop rejected.
        vec(0, 1, 1, 4'h5, 1, 4'h5, 1, 1, "pushpop_empty");

        // Build up to 7 entries.
        for (int i = 0; i < 6; i++) begin
            vec(0, 1, 0, W'(i + 6), i + 2, 4'h5, 1, 1, $sformatf("build%0d", i + 2));
        end

        // Reset wins over push.
        vec(1, 1, 0, 4'h9, 0, 4'h0, 0, 0, "rst_with_push");
        vec(0, 0, 0, 4'h0, 0, 4'h0, 0, 0, "after_rst_idle");

        // Pop while empty.
        vec(0, 0, 1, 4'h0, 0, 4'h0, 0, 1, "pop_empty");
        vec(0, 0, 0, 4'h0, 0, 4'h0, 0, 1, "unf_sticky");

        @(negedge clock);
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            @(negedge clock);
            waited++;
        end
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
